// File: rtl/fpu_result_collector_pkg.sv
// Shared constants and types for the FPU result collector and its classifier.
// Process codes, flag bit positions and the FIFO entry layout live here.
package fpu_result_collector_pkg;

    localparam logic [1:0] PROC_SDIV  = 2'b00;
    localparam logic [1:0] PROC_SSQRT = 2'b01;
    localparam logic [1:0] PROC_DDIV  = 2'b10;
    localparam logic [1:0] PROC_DSQRT = 2'b11;

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    localparam logic [7:0]  SGL_EXP_ONES = 8'hFF;
    localparam logic [10:0] DBL_EXP_ONES = 11'h7FF;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  op;
        logic [2:0]  flags;
    } entry_t;

    function automatic logic is_double_op(input logic [1:0] op);
        return (op == PROC_DDIV) || (op == PROC_DSQRT);
    endfunction

endpackage

// File: rtl/fpu_result_collector_if.sv
// Bus bundle between the FPU result producer, the collector and the host consumer.
// The slave modport is the collector's view; master is the surrounding environment.
interface fpu_result_collector_if #(
    parameter int PTR_W = 2
);
    logic [31:0]    in_zs;
    logic [63:0]    in_zd;
    logic [1:0]     in_op;
    logic           in_z_stb;
    logic           in_z_ack;
    logic [63:0]    out_data;
    logic [1:0]     out_op;
    logic [2:0]     out_flags;
    logic           out_stb;
    logic           out_ack;
    logic [PTR_W:0] count;

    modport slave (
        input  in_zs, in_zd, in_op, in_z_stb, out_ack,
        output in_z_ack, out_data, out_op, out_flags, out_stb, count
    );

    modport master (
        output in_zs, in_zd, in_op, in_z_stb, out_ack,
        input  in_z_ack, out_data, out_op, out_flags, out_stb, count
    );
endinterface

// File: rtl/fpu_result_collector_classify.sv
// Combinational NaN/Inf/zero classifier for single (low 32 bits) or double values.
// Sign bits are deliberately ignored.
module fp_classify
    import fpu_result_collector_pkg::*;
(
    input  logic [63:0] data,
    input  logic        is_double,
    output logic [2:0]  flags
);
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    logic unused_sign;

    assign unused_sign = data[63] ^ data[31];

    always_comb begin
        if (is_double) begin
            exp_ones = (data[62:52] == DBL_EXP_ONES);
            exp_zero = (data[62:52] == 11'h000);
            man_zero = (data[51:0] == 52'h0);
        end else begin
            exp_ones = (data[30:23] == SGL_EXP_ONES);
            exp_zero = (data[30:23] == 8'h00);
            man_zero = (data[22:0] == 23'h0);
        end
        flags            = '0;
        flags[FLAG_NAN]  = exp_ones && !man_zero;
        flags[FLAG_INF]  = exp_ones && man_zero;
        flags[FLAG_ZERO] = exp_zero && man_zero;
    end
endmodule

// File: rtl/fpu_result_collector.sv
// Accepts FPU results over stb/ack, tags and classifies them, and buffers them
// in a small FIFO presented to the host over a second stb/ack port.
module fpu_result_collector
    import fpu_result_collector_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    fpu_result_collector_if.slave  bus
);
    state_t         state;
    state_t         state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0] count_q;
    entry_t         mem [DEPTH];

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           is_dbl;
    logic [63:0]    sel_data;
    logic [2:0]     sel_flags;
    entry_t         wr_entry;
    entry_t         head;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = !empty && bus.out_ack;

    assign is_dbl   = is_double_op(bus.in_op);
    assign sel_data = is_dbl ? bus.in_zd : {32'h0, bus.in_zs};

    fp_classify u_classify (
        .data      (sel_data),
        .is_double (is_dbl),
        .flags     (sel_flags)
    );

    assign wr_entry = '{data: sel_data, op: bus.in_op, flags: sel_flags};

    // Full is judged on the registered count, so a pop in the same cycle
    // does not let a push through until the following IDLE cycle.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_z_stb && !full) begin
                    push       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head          = mem[rd_ptr];
    assign bus.in_z_ack  = (state == ACK);
    assign bus.out_stb   = !empty;
    assign bus.out_data  = empty ? 64'h0 : head.data;
    assign bus.out_op    = empty ? 2'b00 : head.op;
    assign bus.out_flags = empty ? 3'b000 : head.flags;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Table-driven and scoreboard bench for fpu_result_collector: classification vectors,
// back-pressure, simultaneous push/pop, reset mid-handshake and pointer wrap.
module tb_fpu_result_collector;
    import fpu_result_collector_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_result_collector_if #(.PTR_W(PTR_W)) bus ();

    fpu_result_collector #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  op;
        logic [2:0]  flags;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] zs;
        logic [63:0] zd;
        logic [63:0] data;
        logic [2:0]  flags;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] model_flags(input logic [1:0] op, input logic [31:0] zs,
                                               input logic [63:0] zd);
        int   e;
        int   eones;
        logic mz;
        if (op[1]) begin
            e = int'(zd[62:52]); eones = 2047; mz = (zd[51:0] == 52'h0);
        end else begin
            e = int'(zs[30:23]); eones = 255;  mz = (zs[22:0] == 23'h0);
        end
        return {(e == eones) && !mz, (e == eones) && mz, (e == 0) && mz};
    endfunction

    // Scoreboard: every accepted head is compared against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_stb && bus.out_ack) begin
            pops++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got data %0h expected no entry", bus.out_data);
            end else begin
                e = sb.pop_front();
                check("pop_entry", {bus.out_data, bus.out_op, bus.out_flags}, {e.data, e.op, e.flags});
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [31:0] zs, input logic [63:0] zd);
        exp_t e;
        bus.in_op    = op;
        bus.in_zs    = zs;
        bus.in_zd    = zd;
        bus.in_z_stb = 1'b1;
        e.data  = op[1] ? zd : {32'h0, zs};
        e.op    = op;
        e.flags = model_flags(op, zs, zd);
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.in_z_ack) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: in_z_ack=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic release_hs();
        @(posedge clk);
        #1 bus.in_z_stb = 1'b0;
    endtask

    task automatic send(input string name, input int budget, input logic [1:0] op,
                        input logic [31:0] zs, input logic [63:0] zd);
        drive(op, zs, zd);
        wait_ack(name, budget);
        release_hs();
    endtask

    task automatic send_rand(input string name, input int budget);
        logic [63:0] zd;
        zd = {$urandom, $urandom};
        send(name, budget, 2'($urandom_range(0, 3)), $urandom, zd);
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 bus.out_ack = 1'b1;
        @(posedge clk);
        #1 bus.out_ack = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk);
        #1 bus.out_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.count == 0) break;
        end
        check("drain_count", 128'(bus.count), 128'(0));
        @(posedge clk);
        #1 bus.out_ack = 1'b0;
        check("sb_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [10];
        logic [63:0] b_data;
        bit          done;
        int          pops_start;

        vt[0] = '{2'b00, 32'h40400000, 64'h0,                64'h0000000040400000, 3'b000};
        vt[1] = '{2'b11, 32'h0,        64'h7FF0000000000000, 64'h7FF0000000000000, 3'b010};
        vt[2] = '{2'b01, 32'h7FC00000, 64'h0,                64'h000000007FC00000, 3'b100};
        vt[3] = '{2'b10, 32'h0,        64'h8000000000000000, 64'h8000000000000000, 3'b001};
        vt[4] = '{2'b00, 32'h80000000, 64'h7FF8000000000000, 64'h0000000080000000, 3'b001};
        vt[5] = '{2'b01, 32'hFF800000, 64'h0,                64'h00000000FF800000, 3'b010};
        vt[6] = '{2'b11, 32'h7F800000, 64'h7FF0000000000001, 64'h7FF0000000000001, 3'b100};
        vt[7] = '{2'b10, 32'h7FC00000, 64'h3FF0000000000000, 64'h3FF0000000000000, 3'b000};
        vt[8] = '{2'b00, 32'h00000001, 64'h0,                64'h0000000000000001, 3'b000};
        vt[9] = '{2'b10, 32'h7F800000, 64'h0,                64'h0000000000000000, 3'b001};

        bus.in_zs = '0; bus.in_zd = '0; bus.in_op = '0;
        bus.in_z_stb = 1'b0; bus.out_ack = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack",   128'(bus.in_z_ack),  128'(0));
        check("rst_stb",   128'(bus.out_stb),   128'(0));
        check("rst_count", 128'(bus.count),     128'(0));
        check("rst_data",  128'(bus.out_data),  128'(0));
        check("rst_op",    128'(bus.out_op),    128'(0));
        check("rst_flags", 128'(bus.out_flags), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Single div result, one-cycle ack, visible the cycle after capture
        drive(2'b00, 32'h40400000, 64'h0);
        wait_ack("t1_ack", 4);
        check("t1_stb",   128'(bus.out_stb),   128'(1));
        check("t1_data",  128'(bus.out_data),  128'(64'h0000000040400000));
        check("t1_op",    128'(bus.out_op),    128'(0));
        check("t1_flags", 128'(bus.out_flags), 128'(0));
        check("t1_count", 128'(bus.count),     128'(1));
        release_hs();
        @(negedge clk);
        check("t1_ack_one_cycle", 128'(bus.in_z_ack), 128'(0));
        pop_one();

        // Classification table
        for (int i = 0; i < 10; i++) begin
            send("vec_ack", 4, vt[i].op, vt[i].zs, vt[i].zd);
            @(negedge clk);
            check($sformatf("vec%0d_data", i),  128'(bus.out_data),  128'(vt[i].data));
            check($sformatf("vec%0d_flags", i), 128'(bus.out_flags), 128'(vt[i].flags));
            check($sformatf("vec%0d_op", i),    128'(bus.out_op),    128'(vt[i].op));
            pop_one();
        end

        // Back-pressure: fill, stall a 5th, release one slot
        for (int i = 0; i < 4; i++) send_rand("bp_fill_ack", 4);
        @(negedge clk);
        check("bp_count_full", 128'(bus.count), 128'(4));
        drive(2'b10, 32'h0, 64'h7FF0000000000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ack_held", 128'(bus.in_z_ack), 128'(0));
        end
        check("bp_count_hold", 128'(bus.count), 128'(4));
        @(posedge clk);
        #1 bus.out_ack = 1'b1;
        @(posedge clk);
        #1 bus.out_ack = 1'b0;
        @(negedge clk);
        check("bp_count_after_pop", 128'(bus.count), 128'(3));
        wait_ack("bp_5th_ack", 2);
        check("bp_count_refill", 128'(bus.count), 128'(4));
        release_hs();
        drain();

        // Simultaneous push and pop at count=2
        send_rand("pp_a_ack", 4);
        b_data = 64'h0123456789ABCDEF;
        send("pp_b_ack", 4, 2'b11, 32'h0, b_data);
        @(negedge clk);
        check("pp_count_pre", 128'(bus.count), 128'(2));
        @(posedge clk);
        #1;
        drive(2'b01, 32'h3F800000, 64'h0);
        bus.out_ack = 1'b1;
        @(posedge clk);
        #1 bus.out_ack = 1'b0;
        @(negedge clk);
        check("pp_ack",   128'(bus.in_z_ack), 128'(1));
        check("pp_count", 128'(bus.count),    128'(2));
        check("pp_head",  128'(bus.out_data), 128'(b_data));
        release_hs();
        drain();

        // FIFO order over random values with random consumer back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand("rnd_ack", 32);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ack = 1'($urandom_range(0, 1));
                end
                bus.out_ack = 1'b0;
            end
        join
        drain();

        // Reset in the ACK cycle discards the captured entry
        drive(2'b00, 32'h7F800000, 64'h0);
        wait_ack("rst_hs_ack", 4);
        check("rst_hs_count_pre", 128'(bus.count), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_z_stb = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_hs_ack_low", 128'(bus.in_z_ack), 128'(0));
        check("rst_hs_stb",     128'(bus.out_stb),  128'(0));
        check("rst_hs_count",   128'(bus.count),    128'(0));
        send("post_rst_ack", 4, 2'b10, 32'h0, 64'h4000000000000000);
        @(negedge clk);
        check("post_rst_count", 128'(bus.count),   128'(1));
        check("post_rst_stb",   128'(bus.out_stb), 128'(1));
        drain();

        // Pointer wrap: 10 results streamed with the consumer always ready
        pops_start = pops;
        @(posedge clk);
        #1 bus.out_ack = 1'b1;
        for (int i = 0; i < 10; i++) send_rand("wrap_ack", 4);
        drain();
        check("wrap_pop_total", 128'(pops - pops_start), 128'(10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_result_collector.md
Name: fpu_result_collector

Overview:
- Downstream stage of the FPU top (single/double divider and sqrt units). Consumes the merged result bus (single result, double result, result strobe) through the stb/ack handshake.
- Tags each result with its process code, classifies it (NaN/Inf/zero), and buffers it in a small FIFO.
- Presents results to the host/consumer through a second stb/ack port. The FPU never stalls on a slow consumer until the FIFO is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock (FPU clock domain).
- rst  in  1  synchronous, active-high reset.
- in_zs  in  32  single-precision result from the FPU.
- in_zd  in  64  double-precision result from the FPU.
- in_op  in  2  process code of the operation in flight: 00 single div, 01 single sqrt, 10 double div, 11 double sqrt.
- in_z_stb  in  1  result valid from the FPU.
- in_z_ack  out  1  result accepted, registered.
- out_data  out  64  head result; single results zero-extended into [31:0].
- out_op  out  2  head process code.
- out_flags  out  3  head classification {nan, inf, zero}.
- out_stb  out  1  head valid (FIFO not empty).
- out_ack  in  1  consumer accepts head.
- count  out  PTR_W+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - in_z_ack=0, out_stb=0, count=0; pointers cleared; FSM to IDLE.
  - out_data, out_op and out_flags read 0 while empty.
  - Reset mid-handshake aborts it: ack is dropped and the captured entry is discarded.
- Input FSM, states IDLE and ACK:
  - IDLE: if in_z_stb=1 and not full, write the entry at this edge, set in_z_ack<=1, go to ACK. If full, hold in_z_ack=0 and stay in IDLE; the producer stalls.
  - ACK: in_z_ack=1 for exactly one cycle; in_z_stb is ignored in this cycle (the producer drops stb at the edge where it samples ack). Next state IDLE with in_z_ack<=0.
  - Minimum input spacing is 2 cycles per result.
- Entry written:
  - op = in_op.
  - data = in_op[1] ? in_zd : {32'b0, in_zs}.
  - flags computed combinationally from the selected precision at write time:
    - single: nan = exp==8'hFF && man!=0; inf = exp==8'hFF && man==0; zero = exp==0 && man==0; sign is ignored.
    - double: same rules with exp==11'h7FF on [62:52] and man on [51:0].
- Output side:
  - out_stb = (count != 0). out_* are driven from the head entry (read directly from storage; no extra latency).
  - Pop on the edge where out_stb && out_ack. out_ack while empty is ignored.
- Simultaneous push and pop in the same edge: count is unchanged and both pointers advance.
- Full with a pop in the same edge: the push is not taken that cycle, because the full check uses the registered count. The push is taken on the next IDLE cycle with stb still high.
- Pointers wrap modulo DEPTH. count saturates by construction: the RTL never pushes when count==DEPTH and never pops when count==0.
- No data-dependent latency: an accepted result is visible on out_stb at the clk edge after capture (1 cycle).

Decomposition:
- Shared package/defines:
  - process code constants (PROC_SDIV=2'b00, PROC_SSQRT=2'b01, PROC_DDIV=2'b10, PROC_DSQRT=2'b11);
  - flag bit indices (FLAG_NAN=2, FLAG_INF=1, FLAG_ZERO=0);
  - single/double exponent all-ones constants.
- One natural sub-module: fp_classify (combinational; inputs 64-bit data plus is_double, output 3-bit flags). It is reusable by the FPU's exception path.
- FIFO storage and the FSM stay in the top.

Test Plan:
- Single div result: in_op=00, in_zs=32'h40400000, stb held until ack. Required: in_z_ack=1 exactly one cycle. Next cycle out_stb=1, out_data=64'h0000000040400000, out_op=00, out_flags=000, count=1.
- Double sqrt Inf then single NaN: in_zd=64'h7FF0000000000000 with op=11, then in_zs=32'h7FC00000 with op=01. Required out_flags, in order: 010, then 100. in_zd=64'h8000000000000000 with op=10 must give 001.
- Back-pressure: push 4 results with out_ack=0, then a 5th with stb held. Required: count=4 and in_z_ack stays 0. Pulse out_ack once: first entry pops, count=3, then the 5th is acked within 2 cycles and count returns to 4.
- Simultaneous push and pop: count=2, out_ack=1 on the same edge a push is captured. Required: count stays 2, out_data advances to the 2nd entry, and FIFO order is preserved over 8 random values.
- Reset mid-handshake: assert rst in the ACK cycle with count=1. Required: next cycle in_z_ack=0, out_stb=0, count=0. A subsequent push is accepted normally.
- Pointer wrap: stream 10 results at a 2-cycle spacing while out_ack is held high. Required: all 10 emerge in order, with no drops or duplicates.
